// File: rtl/core_muldiv_ctrl_pkg.sv
// ============================================================================
// core_muldiv_ctrl_pkg
//   Shared types for the iterative multiply/divide unit.
//   Rev 1.0
// ============================================================================
`default_nettype none

package core_muldiv_ctrl_pkg;

  typedef enum logic [0:0] {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  localparam logic [3:0] OPCODE_MUL = 4'd8;
  localparam logic [3:0] OPCODE_DIV = 4'd9;

  // Only OPCODE_DIV selects the divider; any other code routed here multiplies.
  function automatic md_op_t md_op_decode(input logic [3:0] opcode);
    md_op_decode = (opcode == OPCODE_DIV) ? MD_DIV : MD_MUL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_muldiv_ctrl_if.sv
// ============================================================================
// core_muldiv_ctrl_if
//   Request/response bundle between the EX stage and the mul/div controller.
//   Rev 1.0
// ============================================================================
`default_nettype none

interface core_muldiv_ctrl_if #(parameter int DATA_W = 32);
  import core_muldiv_ctrl_pkg::*;

  logic              start;
  md_op_t            op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              flush;
  logic              ex_halt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result_hi;
  logic              dz;

  modport master (
    output start, op, opa, opb, flush,
    input  ex_halt, busy, done, result, result_hi, dz
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output ex_halt, busy, done, result, result_hi, dz
  );

endinterface

`default_nettype wire

// File: rtl/core_md_dp.sv
// ============================================================================
// core_md_dp
//   Shift register and shared add/subtract for radix-2 multiply/divide.
//   Rev 1.0
// ============================================================================
`default_nettype none

module core_md_dp
  import core_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  md_op_t            op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] hi_nxt,
  output logic [DATA_W-1:0] lo_nxt
);

  logic              r_is_div;
  logic [DATA_W-1:0] r_opd;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W:0] w_a;
  logic [DATA_W:0] w_b;
  logic [DATA_W:0] w_sum;

  // Single adder: subtraction is add of the inverted operand plus one.
  always_comb begin
    w_a   = r_is_div ? {r_hi, r_lo[DATA_W-1]} : {1'b0, r_hi};
    w_b   = {1'b0, (r_is_div || r_lo[0]) ? r_opd : {DATA_W{1'b0}}};
    w_sum = w_a + (r_is_div ? ~w_b : w_b) + {{DATA_W{1'b0}}, r_is_div};
  end

  always_comb begin
    hi_nxt = r_hi;
    lo_nxt = r_lo;
    if (r_is_div) begin
      if (!w_sum[DATA_W]) begin
        hi_nxt = w_sum[DATA_W-1:0];
        lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_nxt = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
        lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = w_sum[DATA_W:1];
      lo_nxt = {w_sum[0], r_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_opd    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (load) begin
      r_is_div <= (op == MD_DIV);
      r_opd    <= (op == MD_DIV) ? opb : opa;
      r_hi     <= '0;
      r_lo     <= (op == MD_DIV) ? opa : opb;
    end else if (step) begin
      r_hi <= hi_nxt;
      r_lo <= lo_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_muldiv_ctrl.sv
// ============================================================================
// core_muldiv_ctrl
//   Iterative MUL/DIV controller: FSM, step counter, halt and result regs.
//   Rev 1.0
// ============================================================================
`default_nettype none

module core_muldiv_ctrl
  import core_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  core_muldiv_ctrl_if.slave    md
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_result_hi;
  logic              r_dz;

  logic              w_accept;
  logic              w_dz_req;
  logic              w_busy;
  logic              w_step;
  logic              w_last;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;

  assign w_accept = (r_state == S_IDLE) && md.start && !md.flush;
  assign w_dz_req = w_accept && (md.op == MD_DIV) && (md.opb == '0);
  assign w_busy   = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_step   = w_busy && !md.flush;
  assign w_last   = w_step && (r_cnt == CNT_W'(1));

  core_md_dp #(.DATA_W(DATA_W)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .step   (w_step),
    .op     (md.op),
    .opa    (md.opa),
    .opb    (md.opb),
    .hi_nxt (w_hi_nxt),
    .lo_nxt (w_lo_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_dz_req)              w_state_nxt = S_DONE;
          else if (md.op == MD_DIV)  w_state_nxt = S_DIV;
          else                       w_state_nxt = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (md.flush)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_dz        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)    r_cnt <= CNT_W'(DATA_W);
      else if (w_step) r_cnt <= r_cnt - CNT_W'(1);
      // Results are captured from the datapath's next value on the final step.
      if (w_dz_req) begin
        r_result    <= '1;
        r_result_hi <= md.opa;
        r_dz        <= 1'b1;
      end else if (w_last) begin
        r_result    <= w_lo_nxt;
        r_result_hi <= w_hi_nxt;
        if (r_state == S_DIV) r_dz <= 1'b0;
      end
    end
  end

  assign md.ex_halt   = w_accept || w_busy;
  assign md.busy      = w_busy;
  assign md.done      = (r_state == S_DONE);
  assign md.result    = r_result;
  assign md.result_hi = r_result_hi;
  assign md.dz        = r_dz;

endmodule

`default_nettype wire

// File: doc/core_muldiv_ctrl.md
# core_muldiv_ctrl

Iterative multiply/divide controller for the EX stage. It accepts one MUL or DIV request from the issuing stage, runs a radix-2 shift-add multiply or restoring divide over `DATA_W` cycles, and holds the pipeline through `ex_halt` while it is busy. It produces a one-cycle `done` strobe with registered results. The EX writeback mux selects `result` for `OPCODE_MUL` and `OPCODE_DIV`, in place of a single-cycle ALU result.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `op`  in  `md_op_t`  operation: `MD_MUL` (unsigned product) or `MD_DIV` (unsigned divide).
- `opa`  in  `DATA_W`  multiplicand or dividend.
- `opb`  in  `DATA_W`  multiplier or divisor.
- `flush`  in  1  abort the in-flight operation; same source as the EX flush.
- `ex_halt`  out  1  pipeline hold request to EX and earlier stages.
- `busy`  out  1  state is MUL or DIV.
- `done`  out  1  one-cycle completion strobe.
- `result`  out  `DATA_W`  low product, or quotient.
- `result_hi`  out  `DATA_W`  high product, or remainder.
- `dz`  out  1  divide-by-zero flag for the last completed DIV.

## Operation
- States:
  - IDLE
  - MUL
  - DIV
  - DONE
- Reset values: state=IDLE, counter=0, `result`=0, `result_hi`=0, `dz`=0, `done`=0, `busy`=0.
- IDLE, when `start && !flush`:
  - Latch `opa` and `opb`.
  - Clear the accumulator.
  - Load counter=`DATA_W`.
  - Go to MUL or DIV according to `op`.
- IDLE, DIV with `opb`==0: go directly to DONE with `result`=all-ones, `result_hi`=`opa`, `dz`=1.
- MUL step:
  - If multiplier bit0 is set, add the multiplicand to the upper accumulator with a (`DATA_W`+1)-bit carry.
  - Shift the {carry, acc_hi, acc_lo} register right by 1.
  - Decrement the counter.
- DIV step:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem in `DATA_W`+1 bits.
  - If the result is non-negative, commit it and set quo bit0=1.
  - Decrement the counter.
- Counter reaching 0 after a step: go to DONE and load `result` and `result_hi`. A non-zero DIV clears `dz`.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `result`, `result_hi` and `dz` hold until the next accepted start.
- `ex_halt` = (IDLE & `start` & !`flush`) | MUL | DIV. It is combinational and is low in DONE, so the consuming instruction advances in that same cycle.
- `start` while not IDLE: ignored. There is no queueing.
- `flush` in MUL or DIV: go to IDLE next edge. No `done` is produced, and `result`, `result_hi` and `dz` are unchanged.
- `flush` in DONE: `done` is still asserted that cycle. The consumer discards it.
- `flush` together with `start` in IDLE: the request is dropped.
- `rst` has priority over everything. Asserting it mid-operation returns the block to reset values next edge.

## Timing
- Start accepted at edge k:
  - `busy`=1 for cycles k+1 … k+`DATA_W`.
  - `done`=1 in cycle k+`DATA_W`+1.
  - `ex_halt` is high from the request cycle through cycle k+`DATA_W`.
- Divide by zero: `done` in cycle k+1, and `ex_halt` is high only in the request cycle.
- Back-to-back operations: the earliest next start is sampled in the cycle after DONE, giving a throughput of 1 op per `DATA_W`+2 cycles.
- Counter width is $clog2(`DATA_W`)+1.
- Each step contains only one `DATA_W`+1 add/subtract. No multi-cycle paths.

## Structure
- Add `md_op_t` (`MD_MUL`, `MD_DIV`) and `md_state_t` (IDLE, MUL, DIV, DONE) to `i2d_core_defines.sv`. The opcode-to-`md_op_t` decode also lives there as a function.
- One sub-module is natural: `core_md_dp`, which holds the accumulator/shift register and adder/subtractor, with step/load/op controls. `core_muldiv_ctrl` keeps the FSM, counter, halt logic and output registers.

## Test plan
- MUL 7×6 → `done` at k+33, `result`=42, `result_hi`=0, and `ex_halt` is high for exactly 33 cycles.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `result`=0x00000001, `result_hi`=0xFFFFFFFE.
- DIV 100/7 → `result`=14, `result_hi`=2, `dz`=0. Then DIV 0x80000000/1 → `result`=0x80000000, `result_hi`=0.
- DIV 5/0 → `done` at k+1, `result`=0xFFFFFFFF, `result_hi`=5, `dz`=1, `ex_halt` high for 1 cycle only.
- Flush boundaries:
  - Start MUL 3×3, then assert `flush` at k+10 → IDLE at k+11, no `done`, `result` keeps its previous value (42), `ex_halt` is low from k+11.
  - `start`+`flush` in the same cycle → no acceptance.
- Pulse `rst` at k+5 of a DIV → all outputs at reset values next cycle. A new MUL 2×3 then yields 6. A `start` asserted during MUL is ignored.
